// File: rtl/serial_rx_if.sv
// Serial receiver link bundle.
// Carries the serial line into the receiver and the recovered word, strobes
// and busy flag back out.
//   serial_in  : serial line, idles high (driven by the link side)
//   data_out   : last accepted word
//   valid_out  : one-cycle strobe, data_out updated
//   busy_out   : frame in progress or waiting for line idle
//   parity_err : one-cycle strobe with valid_out, parity mismatch
//   frame_err  : one-cycle strobe, stop bit sampled low
// modport master : the receiver (consumes serial_in, drives the rest)
// modport slave  : the link/consumer side
interface serial_rx_if #(
    parameter int DATA_W = 4
) ();
    logic              serial_in;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              busy_out;
    logic              parity_err;
    logic              frame_err;

    modport master (
        input  serial_in,
        output data_out,
        output valid_out,
        output busy_out,
        output parity_err,
        output frame_err
    );

    modport slave (
        output serial_in,
        input  data_out,
        input  valid_out,
        input  busy_out,
        input  parity_err,
        input  frame_err
    );
endinterface

// File: rtl/serial_rx.sv
// Serial frame receiver.
// Recovers frames of the form: start (0), DATA_W data bits LSB first,
// optional even parity bit, stop (1). The line is synchronous to clk.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   rx  : serial_rx_if.master (serial_in in; data_out, valid_out, busy_out,
//         parity_err, frame_err out, all registered)
module serial_rx #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_EN    = 1
) (
    input  logic         clk,
    input  logic         rst,
    serial_rx_if.master  rx
);
    // Start bit is checked half a bit after its falling edge; every later
    // sample lands a whole bit period after the previous one.
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    localparam int BW   = $clog2(DATA_W + 1);

    localparam logic [CW-1:0] CYC_ZERO_C = CW'(0);
    localparam logic [CW-1:0] CYC_ONE_C  = CW'(1);
    localparam logic [CW-1:0] HALF_C     = CW'(HALF);
    localparam logic [CW-1:0] CPB_C      = CW'(CLKS_PER_BIT);
    localparam logic [BW-1:0] BIT_ZERO_C = BW'(0);
    localparam logic [BW-1:0] BIT_ONE_C  = BW'(1);
    localparam logic [BW-1:0] LAST_BIT_C = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } state_t;

    state_t            state_r,   state_s;
    logic [CW-1:0]     cyc_cnt_r, cyc_cnt_s;
    logic [BW-1:0]     bit_cnt_r, bit_cnt_s;
    logic [DATA_W-1:0] shift_r,   shift_s;
    logic [DATA_W-1:0] data_r,    data_s;
    logic              par_bad_r, par_bad_s;
    logic              valid_r,   valid_s;
    logic              busy_r,    busy_s;
    logic              perr_r,    perr_s;
    logic              ferr_r,    ferr_s;
    logic              bit_slot_s;

    // Even parity of a data word: 1 when the word holds an odd number of ones.
    function automatic logic even_parity(input logic [DATA_W-1:0] word);
        return ^word;
    endfunction

    // Shift a new bit in at the MSB end; after DATA_W shifts the first
    // (LSB-first) bit sits at bit 0. Works for DATA_W = 1 as well.
    function automatic logic [DATA_W-1:0] shift_in_msb(
        input logic [DATA_W-1:0] sr,
        input logic              b
    );
        logic [DATA_W-1:0] res;
        res             = sr >> 1;
        res[DATA_W-1]   = b;
        return res;
    endfunction

    // cyc_cnt_r counts edges since the previous sample point.
    assign bit_slot_s = (cyc_cnt_r == CPB_C);

    // Next-state, counter and output decode.
    always_comb begin
        state_s   = state_r;
        cyc_cnt_s = cyc_cnt_r;
        bit_cnt_s = bit_cnt_r;
        shift_s   = shift_r;
        data_s    = data_r;
        par_bad_s = par_bad_r;
        valid_s   = 1'b0;
        perr_s    = 1'b0;
        ferr_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (rx.serial_in == 1'b0) begin
                    // This edge is E0; with HALF = 0 it is also the start check.
                    cyc_cnt_s = CYC_ONE_C;
                    bit_cnt_s = BIT_ZERO_C;
                    par_bad_s = 1'b0;
                    if (HALF == 0) begin
                        state_s = ST_DATA;
                    end else begin
                        state_s = ST_START;
                    end
                end else begin
                    cyc_cnt_s = CYC_ZERO_C;
                end
            end

            ST_START: begin
                if (cyc_cnt_r == HALF_C) begin
                    if (rx.serial_in == 1'b1) begin
                        // Low pulse too short to be a start bit.
                        state_s   = ST_IDLE;
                        cyc_cnt_s = CYC_ZERO_C;
                    end else begin
                        state_s   = ST_DATA;
                        cyc_cnt_s = CYC_ONE_C;
                    end
                end else begin
                    cyc_cnt_s = cyc_cnt_r + CYC_ONE_C;
                end
            end

            ST_DATA: begin
                if (bit_slot_s) begin
                    cyc_cnt_s = CYC_ONE_C;
                    shift_s   = shift_in_msb(shift_r, rx.serial_in);
                    if (bit_cnt_r == LAST_BIT_C) begin
                        bit_cnt_s = BIT_ZERO_C;
                        if (PARITY_EN != 0) begin
                            state_s = ST_PARITY;
                        end else begin
                            state_s = ST_STOP;
                        end
                    end else begin
                        bit_cnt_s = bit_cnt_r + BIT_ONE_C;
                    end
                end else begin
                    cyc_cnt_s = cyc_cnt_r + CYC_ONE_C;
                end
            end

            ST_PARITY: begin
                if (bit_slot_s) begin
                    cyc_cnt_s = CYC_ONE_C;
                    par_bad_s = rx.serial_in ^ even_parity(shift_r);
                    state_s   = ST_STOP;
                end else begin
                    cyc_cnt_s = cyc_cnt_r + CYC_ONE_C;
                end
            end

            ST_STOP: begin
                if (bit_slot_s) begin
                    cyc_cnt_s = CYC_ZERO_C;
                    if (rx.serial_in == 1'b1) begin
                        data_s  = shift_r;
                        valid_s = 1'b1;
                        perr_s  = par_bad_r;
                        state_s = ST_IDLE;
                    end else begin
                        ferr_s  = 1'b1;
                        state_s = ST_WAIT_HIGH;
                    end
                end else begin
                    cyc_cnt_s = cyc_cnt_r + CYC_ONE_C;
                end
            end

            ST_WAIT_HIGH: begin
                // A broken frame leaves the line low; do not mistake that
                // for a new start bit.
                cyc_cnt_s = CYC_ZERO_C;
                if (rx.serial_in == 1'b1) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_HIGH;
                end
            end

            default: begin
                state_s   = ST_IDLE;
                cyc_cnt_s = CYC_ZERO_C;
                bit_cnt_s = BIT_ZERO_C;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State, counters, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cyc_cnt_r <= CYC_ZERO_C;
            bit_cnt_r <= BIT_ZERO_C;
            shift_r   <= '0;
            data_r    <= '0;
            par_bad_r <= 1'b0;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            perr_r    <= 1'b0;
            ferr_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cyc_cnt_r <= cyc_cnt_s;
            bit_cnt_r <= bit_cnt_s;
            shift_r   <= shift_s;
            data_r    <= data_s;
            par_bad_r <= par_bad_s;
            valid_r   <= valid_s;
            busy_r    <= busy_s;
            perr_r    <= perr_s;
            ferr_r    <= ferr_s;
        end
    end

    assign rx.data_out   = data_r;
    assign rx.valid_out  = valid_r;
    assign rx.busy_out   = busy_r;
    assign rx.parity_err = perr_r;
    assign rx.frame_err  = ferr_r;
endmodule

// File: tb/tb_serial_rx.sv
// Testbench for serial_rx. Two receivers share a clock: A (CLKS_PER_BIT=1)
// and B (CLKS_PER_BIT=4), both DATA_W=4 with even parity. Each gets a line
// waveform built from directed frames followed by random frames. While the
// waveform is built, the expected per-edge outputs are computed from frame
// timing arithmetic: E0 is the first low edge of a frame and the stop bit is
// sampled at E0 + HALF + (DATA_W+2)*CLKS_PER_BIT.
module tb_serial_rx;
    localparam int N  = 2000;
    localparam int DW = 4;

    logic clk;
    logic rst_a;
    logic rst_b;

    serial_rx_if #(.DATA_W(DW)) if_a ();
    serial_rx_if #(.DATA_W(DW)) if_b ();

    serial_rx #(.DATA_W(DW), .CLKS_PER_BIT(1), .PARITY_EN(1)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .rx  (if_a.master)
    );

    serial_rx #(.DATA_W(DW), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .rx  (if_b.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line level seen at each edge, and expected outputs after each edge.
    bit         line_m [2][N];
    bit         busy_m [2][N];
    bit         vld_m  [2][N];
    bit         perr_m [2][N];
    bit         ferr_m [2][N];
    bit         rst_m  [2][N];
    logic [3:0] vdat_m [2][N];
    logic [3:0] expd_m [2][N];
    int         pos [2];
    int         n_cmp;
    int         n_mis;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int cpb_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic int half_of(input int d);
        return (cpb_of(d) - 1) / 2;
    endfunction

    task automatic put(input int d, input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            if (pos[d] < N) line_m[d][pos[d]] = v;
            pos[d]++;
        end
    endtask

    task automatic mark_busy(input int d, input int from, input int upto);
        for (int k = from; k < upto; k++) begin
            if (k < N) busy_m[d][k] = 1'b1;
        end
    endtask

    // Whole frame; optional wrong parity, or a low stop bit followed by
    // extra_low further low cycles and one high cycle.
    task automatic send_frame(input int d, input logic [3:0] dv, input bit par_flip,
                              input bit stop_bad, input int extra_low);
        int  c;
        int  e0;
        int  s;
        bit  par;
        c   = cpb_of(d);
        e0  = pos[d];
        s   = e0 + half_of(d) + (DW + 2) * c;
        par = (^dv) ^ par_flip;
        put(d, 1'b0, c);
        for (int i = 0; i < DW; i++) put(d, dv[i], c);
        put(d, par, c);
        put(d, ~stop_bad, c);
        mark_busy(d, e0, s);
        if (s < N) begin
            if (!stop_bad) begin
                vld_m[d][s]  = 1'b1;
                vdat_m[d][s] = dv;
                perr_m[d][s] = par_flip;
            end else begin
                put(d, 1'b0, extra_low);
                ferr_m[d][s] = 1'b1;
                mark_busy(d, s, pos[d]);
                put(d, 1'b1, 1);
            end
        end
    endtask

    // One-cycle low pulse, rejected at the half-bit check (needs HALF >= 1).
    task automatic glitch(input int d);
        mark_busy(d, pos[d], pos[d] + 1);
        put(d, 1'b0, 1);
        put(d, 1'b1, 1);
    endtask

    // Frame cut off by reset right after data bit nbits-1 is sampled.
    task automatic abort_frame(input int d, input logic [3:0] dv, input int nbits);
        int c;
        int e0;
        int r;
        c  = cpb_of(d);
        e0 = pos[d];
        r  = e0 + half_of(d) + nbits * c;
        put(d, 1'b0, c);
        for (int i = 0; i < nbits; i++) put(d, dv[i], c);
        mark_busy(d, e0, r);
        if (r < N) rst_m[d][r] = 1'b1;
        put(d, 1'b1, 2);
    endtask

    task automatic build_random(input int d);
        int  r;
        bit  sb;
        while (pos[d] < N - 80) begin
            r = $urandom_range(0, 9);
            if (d == 1 && r == 0) begin
                glitch(d);
                put(d, 1'b1, $urandom_range(0, 2));
            end else begin
                sb = ($urandom_range(0, 7) == 0);
                send_frame(d, 4'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0),
                           sb, $urandom_range(0, 5));
                put(d, 1'b1, $urandom_range(0, 2));
            end
        end
    endtask

    task automatic check_all(input int d, input int k, input logic [3:0] dat, input logic v,
                             input logic b, input logic pe, input logic fe);
        string nm;
        nm = (d == 0) ? "A" : "B";
        check_eq($sformatf("%s valid c%0d", nm, k), 32'(v),   32'(vld_m[d][k]));
        check_eq($sformatf("%s data c%0d", nm, k),  32'(dat), 32'(expd_m[d][k]));
        check_eq($sformatf("%s busy c%0d", nm, k),  32'(b),   32'(busy_m[d][k]));
        check_eq($sformatf("%s perr c%0d", nm, k),  32'(pe),  32'(perr_m[d][k]));
        check_eq($sformatf("%s ferr c%0d", nm, k),  32'(fe),  32'(ferr_m[d][k]));
    endtask

    initial begin
        logic [3:0] run;
        n_cmp = 0;
        n_mis = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        if_a.serial_in = 1'b1;
        if_b.serial_in = 1'b1;
        for (int d = 0; d < 2; d++) begin
            pos[d] = 0;
            for (int k = 0; k < N; k++) begin
                line_m[d][k] = 1'b1;
                busy_m[d][k] = 1'b0;
                vld_m[d][k]  = 1'b0;
                perr_m[d][k] = 1'b0;
                ferr_m[d][k] = 1'b0;
                rst_m[d][k]  = 1'b0;
                vdat_m[d][k] = 4'h0;
            end
        end

        // Receiver A: directed cases, then random frames.
        put(0, 1'b1, 3);
        send_frame(0, 4'h5, 1'b0, 1'b0, 0);
        put(0, 1'b1, 2);
        send_frame(0, 4'hA, 1'b0, 1'b0, 0);
        send_frame(0, 4'h6, 1'b0, 1'b0, 0);
        send_frame(0, 4'h7, 1'b0, 1'b0, 0);
        send_frame(0, 4'h9, 1'b0, 1'b0, 0);
        put(0, 1'b1, 2);
        send_frame(0, 4'h6, 1'b1, 1'b0, 0);
        put(0, 1'b1, 1);
        send_frame(0, 4'h9, 1'b0, 1'b1, 5);
        send_frame(0, 4'h3, 1'b0, 1'b0, 0);
        put(0, 1'b1, 2);
        abort_frame(0, 4'h5, 3);
        send_frame(0, 4'hA, 1'b0, 1'b0, 0);
        put(0, 1'b1, 2);
        build_random(0);

        // Receiver B: short start pulse, full frame, then random traffic.
        put(1, 1'b1, 3);
        glitch(1);
        put(1, 1'b1, 3);
        send_frame(1, 4'hC, 1'b0, 1'b0, 0);
        put(1, 1'b1, 2);
        build_random(1);

        // Expected data_out: last accepted word, cleared by reset.
        for (int d = 0; d < 2; d++) begin
            run = 4'h0;
            for (int k = 0; k < N; k++) begin
                if (vld_m[d][k]) run = vdat_m[d][k];
                if (rst_m[d][k]) run = 4'h0;
                expd_m[d][k] = run;
            end
        end

        // Reset state.
        #2;
        check_eq("A rst data",  32'(if_a.data_out),   32'h0);
        check_eq("A rst valid", 32'(if_a.valid_out),  32'h0);
        check_eq("A rst busy",  32'(if_a.busy_out),   32'h0);
        check_eq("A rst perr",  32'(if_a.parity_err), 32'h0);
        check_eq("A rst ferr",  32'(if_a.frame_err),  32'h0);
        check_eq("B rst data",  32'(if_b.data_out),   32'h0);
        check_eq("B rst busy",  32'(if_b.busy_out),   32'h0);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        for (int k = 0; k < N; k++) begin
            if_a.serial_in = line_m[0][k];
            if_b.serial_in = line_m[1][k];
            @(posedge clk);
            #1;
            if (rst_m[0][k]) rst_a = 1'b1;
            if (rst_m[1][k]) rst_b = 1'b1;
            @(negedge clk);
            check_all(0, k, if_a.data_out, if_a.valid_out, if_a.busy_out,
                      if_a.parity_err, if_a.frame_err);
            check_all(1, k, if_b.data_out, if_b.valid_out, if_b.busy_out,
                      if_b.parity_err, if_b.frame_err);
            #1;
            rst_a = 1'b0;
            rst_b = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
